// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_e;
  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR} sel_e;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/jump_target_fmt.sv
// Jump-address concatenation: keep the 256MB region of pc+4, splice in the word index.
module jump_target_fmt (
  input  logic [31:0] pc4,
  input  logic [25:0] jmp_target,
  output logic [31:0] target
);
  assign target = {pc4[31:28], jmp_target, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// Single-outstanding fetch controller: owns the PC, holds the fetched word for decode,
// and forms the next PC from sequential/branch/jump/jump-register sources.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp_valid,
  input  logic [25:0] jmp_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_addr,
  output logic        misalign
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc4, br_tgt, jmp_tgt, next_pc;
  sel_e        sel;

  assign pc4    = pc_q + PC_INC;
  assign br_tgt = pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};

  jump_target_fmt u_jfmt (
    .pc4        (pc4),
    .jmp_target (jmp_target),
    .target     (jmp_tgt)
  );

  // Fixed priority: jr > jmp > br > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (jr_valid)       sel = SEL_JR;
    else if (jmp_valid) sel = SEL_JMP;
    else if (br_taken)  sel = SEL_BR;
  end

  always_comb begin
    next_pc = pc4;
    case (sel)
      SEL_JR:  next_pc = {jr_addr[31:2], 2'b00};
      SEL_JMP: next_pc = jmp_tgt;
      SEL_BR:  next_pc = br_tgt;
      default: next_pc = pc4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: if (imem_ack) begin
        instr_d    = imem_rdata;
        instr_pc_d = pc_q;
        state_d    = HOLD;
      end
      HOLD: if (instr_ready) begin
        pc_d       = next_pc;
        misalign_d = (sel == SEL_JR) && (jr_addr[1:0] != 2'b00);
        state_d    = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: redirect vector table plus stall and reset sequences,
// fetch addresses checked through an expected-address queue.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        br_taken, jmp_valid, jr_valid, misalign;
  logic [15:0] br_offset;
  logic [25:0] jmp_target;
  logic [31:0] jr_addr;

  pc_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .jr_valid(jr_valid), .jr_addr(jr_addr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] tgt;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_redirects();
    instr_ready = 0; br_taken = 0; br_offset = 0; jmp_valid = 0;
    jmp_target = 0; jr_valid = 0; jr_addr = 0;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sb_empty: got no expected address want one");
      a = imem_addr;
    end else begin
      a = sb.pop_front();
      chk("imem_addr", imem_addr, a);
    end
  endtask

  // One full fetch/accept: wait for request, optional ack stall, optional ready stall
  // with junk redirects, then accept with v's redirects and expect v.exp_pc next.
  task automatic do_fetch(input vec_t v, input logic [31:0] rdata, input int ack_dly, input int rdy_dly);
    logic [31:0] cur;
    wait_req(cur);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 0; imem_rdata = ~rdata;
      step();
      chk("ack_stall_req", {31'b0, imem_req}, 32'd1);
      chk("ack_stall_addr", imem_addr, cur);
    end
    imem_ack = 1; imem_rdata = rdata;
    step();
    imem_ack = 0; imem_rdata = 32'hBAD0_BAD0;
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("instr", instr, rdata);
    chk("instr_pc", instr_pc, cur);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready = 0; jr_valid = 1; jr_addr = 32'hDEAD_BEE3;
      jmp_valid = i[0]; jmp_target = 26'h3FF_FFFF; br_taken = 1; br_offset = 16'h7777;
      step();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, rdata);
      chk("stall_pc", instr_pc, cur);
      chk("stall_mis", {31'b0, misalign}, 32'd0);
    end
    instr_ready = 1; br_taken = v.br; br_offset = v.off; jmp_valid = v.jmp;
    jmp_target = v.tgt; jr_valid = v.jr; jr_addr = v.jra;
    sb.push_back(v.exp_pc);
    step();
    idle_redirects();
    chk("acc_mis", {31'b0, misalign}, {31'b0, v.exp_mis});
    chk("acc_req", {31'b0, imem_req}, 32'd1);
    chk("acc_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("mis_drop", {31'b0, misalign}, 32'd0);
  endtask

  vec_t vt[9];
  vec_t sv;
  logic [31:0] a;

  initial begin
    vt[0] = '{32'h0FFF_FFFC, 0, 16'h0,    1, 26'h0000010, 0, 32'h0,         32'h1000_0040, 0};
    vt[1] = '{32'h0000_0100, 1, 16'hFFFE, 0, 26'h0,       0, 32'h0,         32'h0000_00FC, 0};
    vt[2] = '{32'h0000_1000, 1, 16'h0004, 1, 26'h0000123, 1, 32'h0000_2003, 32'h0000_2000, 1};
    vt[3] = '{32'hFFFF_FFFC, 0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0000, 0};
    vt[4] = '{32'h0000_0040, 1, 16'h0010, 0, 26'h0,       0, 32'h0,         32'h0000_0084, 0};
    vt[5] = '{32'h4000_0000, 1, 16'h0001, 1, 26'h3FF_FFFF, 0, 32'h0,        32'h4FFF_FFFC, 0};
    vt[6] = '{32'h0000_0200, 1, 16'h8000, 1, 26'h0000005, 0, 32'h0,         32'h0000_0014, 0};
    vt[7] = '{32'h0000_0300, 0, 16'h0,    0, 26'h0,       1, 32'h1234_5678, 32'h1234_5678, 0};
    vt[8] = '{32'h7FFF_FFFC, 1, 16'h7FFF, 0, 26'h0,       0, 32'h0,         32'h8001_FFFC, 0};

    rst_n = 0; imem_ack = 0; imem_rdata = 0;
    idle_redirects();
    step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1;
    #1 chk("boot_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("req_rise", {31'b0, imem_req}, 32'd1);

    // Back-to-back sequential fetch from reset.
    sb.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      sv = '{32'h0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'(4 * (i + 1)), 0};
      do_fetch(sv, 32'h1000_0000 + 32'(i), 0, 0);
    end

    // Redirect table: steer PC there with an aligned jr, then apply the vector.
    for (int i = 0; i < 9; i++) begin
      sv = '{32'h0, 0, 16'h0, 0, 26'h0, 1, vt[i].pc, vt[i].pc, 0};
      do_fetch(sv, 32'hC000_0000 + 32'(i), 0, 0);
      do_fetch(vt[i], 32'hA500_0000 + 32'(i), (i == 1) ? 3 : 0, (i == 1) ? 4 : 0);
    end

    // Reset during REQ with a simultaneous ack.
    wait_req(a);
    rst_n = 0; imem_ack = 1; imem_rdata = 32'h5555_AAAA;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    step();
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 0; rst_n = 1;
    sb.delete();
    sb.push_back(32'h0);
    sv = '{32'h0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h4, 0};
    do_fetch(sv, 32'h7777_0000, 1, 0);
    wait_req(a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction-fetch controller that owns the program counter and sequences next-PC formation for the lab processor. It issues one fetch at a time to instruction memory and holds each fetched word for decode. When decode accepts the word, it selects the next PC from four sources: sequential, branch, jump or jump-register. The jump source is the 32-bit word {PC+4[31:28], target[25:0], 2'b00}, so this block is the single sequencer in front of the jump-address concatenation datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  fetch request, held high until imem_ack.
- imem_addr  output  32  fetch address, equal to the current PC while imem_req is high.
- imem_ack  input  1  memory returns the word in the same cycle; sampled only while imem_req=1.
- imem_rdata  input  32  fetched word, valid when imem_ack=1.
- instr_valid  output  1  a fetched instruction is held for decode.
- instr  output  32  held instruction word.
- instr_pc  output  32  PC of the held instruction.
- instr_ready  input  1  decode accepts the held instruction this cycle.
- br_taken  input  1  redirect to the branch target; sampled with instr_ready.
- br_offset  input  16  signed word offset.
- jmp_valid  input  1  redirect to the jump target; sampled with instr_ready.
- jmp_target  input  26  jump index field.
- jr_valid  input  1  redirect to a register target; sampled with instr_ready.
- jr_addr  input  32  register target address.
- misalign  output  1  one-cycle pulse when an accepted jr_addr has [1:0]≠0.

## Operation
- The FSM has three states:
  - BOOT: entered while rst_n=0. Leaves to REQ on the first clock after rst_n deasserts.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack, capture instr←imem_rdata and instr_pc←pc, then go to HOLD. Otherwise stay in REQ.
  - HOLD: instr_valid=1. On instr_ready, load pc←next_pc and go to REQ. Otherwise hold every output stable.
- next_pc is selected in fixed priority jr > jmp > br > sequential:
  - jr: {jr_addr[31:2], 2'b00}. misalign pulses the next cycle if jr_addr[1:0]≠0.
  - jmp: {pc4[31:28], jmp_target, 2'b00}, where pc4 = pc+4.
  - br: pc4 + ({{14{br_offset[15]}}, br_offset, 2'b00}).
  - sequential: pc4.
- All arithmetic is modulo 2^32, and wrap-around is silent: pc=32'hFFFF_FFFC goes sequentially to 32'h0000_0000.
- Redirect inputs are ignored unless instr_ready=1 and the FSM is in HOLD.
- When several redirect inputs are valid at once, only the highest-priority one takes effect.

## Timing
- Reset values:
  - pc=RESET_PC.
  - imem_req=0, instr_valid=0, misalign=0.
  - instr=0, instr_pc=0, imem_addr=RESET_PC.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- imem_req rises 1 cycle after reset deasserts.
- With imem_ack in the first REQ cycle, instr_valid rises the next cycle.
- Minimum throughput is 2 cycles per instruction (REQ, HOLD) when imem_ack and instr_ready both arrive immediately.
- A new imem_req starts the cycle after acceptance, carrying the new PC.
- imem_req never drops before imem_ack, and imem_addr never changes while imem_req=1.
- rst_n asserted in any state forces BOOT immediately. Any outstanding request is abandoned and a late imem_ack is ignored.

## Structure
- Shared package pc_seq_pkg holds:
  - state typedef {BOOT, REQ, HOLD}.
  - PC_INC=32'd4.
  - redirect-select typedef {SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR}.
- One combinational sub-module, jump_target_fmt, forms {pc4[31:28], jmp_target, 2'b00}. It is instantiated once inside pc_sequencer.

## Test plan
- Reset then sequential fetch: with RESET_PC=0 and ack/ready always high, imem_addr runs 0x0, 0x4, 0x8, with imem_req high every other cycle.
- Jump across a region boundary: instr_pc=32'h0FFF_FFFC, jmp_valid=1, jmp_target=26'h0000010 → next imem_addr=32'h1000_0040.
- Branch backward: instr_pc=32'h0000_0100, br_taken=1, br_offset=16'hFFFE → next imem_addr=32'h0000_00FC.
- Simultaneous redirects: jr_valid=1 with jr_addr=32'h0000_2003, plus jmp_valid=1 and br_taken=1.
  - next imem_addr=32'h0000_2000.
  - misalign pulses for exactly 1 cycle.
- Stalls: hold imem_ack low for 3 cycles, then instr_ready low for 4 cycles.
  - imem_addr stays stable throughout the ack stall.
  - instr, instr_pc and instr_valid stay stable throughout the ready stall.
  - Redirect inputs toggled while instr_ready=0 have no effect.
- Reset mid-fetch: assert rst_n=0 while in REQ, then ack arrives → all outputs are at reset values in that same cycle, and fetch restarts at RESET_PC.
